grf_write_arbiter: RTL and testbench

GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

---
 rtl/grf_write_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/grf_write_arbiter.sv | 92 +++++++++
 tb/tb_grf_write_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_write_arbiter_pkg.sv
// Shared widths and payload types for the register-file write arbiter.
package grf_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned REG_COUNT          = 32;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  // Stored part of an MDU result; the live bit is kept separately so it can be reset.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] a3;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     pc;
  } wb_payload_t;

endpackage

// File: rtl/wb_fifo.sv
// MDU result queue with per-entry live bits.
// Ports: clk/reset; push + push_a3/wd/pc; pop; inv_en/inv_a3 kill live entries
// for a register; head_* expose the oldest entry; empty, count, pend_mask status.
module wb_fifo
  import grf_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [REG_ADDR_W-1:0]         push_a3,
  input  logic [DATA_W-1:0]             push_wd,
  input  logic [DATA_W-1:0]             push_pc,
  input  logic                          pop,
  input  logic                          inv_en,
  input  logic [REG_ADDR_W-1:0]         inv_a3,
  output logic                          head_live,
  output logic [REG_ADDR_W-1:0]         head_a3,
  output logic [DATA_W-1:0]             head_wd,
  output logic [DATA_W-1:0]             head_pc,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic [REG_COUNT-1:0]          pend_mask
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FIFO_DEPTH-1:0] live;
  logic [FIFO_DEPTH-1:0] live_nxt;
  wb_payload_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;

  assign empty     = (count == '0);
  assign head_live = live[head];
  assign head_a3   = mem[head].a3;
  assign head_wd   = mem[head].wd;
  assign head_pc   = mem[head].pc;

  // Live-bit update: popped or superseded entries die; a push is born dead
  // when the pipeline writes the same register on that edge.
  always_comb begin
    live_nxt = live;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if ((pop && (head == PTR_W'(i))) || (inv_en && (mem[i].a3 == inv_a3))) begin
        live_nxt[i] = 1'b0;
      end
    end
    if (push) begin
      live_nxt[tail] = !(inv_en && (push_a3 == inv_a3));
    end
  end

  // Pointers, occupancy and live bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      live  <= live_nxt;
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; it is only observed through live bits.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{a3: push_a3, wd: push_wd, pc: push_pc};
    end
  end

  // One-hot OR of live destinations; r0 is never pending.
  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (live[i]) begin
        pend_mask[mem[i].a3] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single register-file write port between the retiring
// pipeline (never stalled) and queued MDU results.
// Ports: clk/reset; pl_* pipeline write request; md_* MDU result handshake;
// grf_* registered write port; pend_mask/md_count queue status.
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pl_we,
  input  logic [REG_ADDR_W-1:0]       pl_a3,
  input  logic [DATA_W-1:0]           pl_wd,
  input  logic [DATA_W-1:0]           pl_pc,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [REG_ADDR_W-1:0]       md_a3,
  input  logic [DATA_W-1:0]           md_wd,
  input  logic [DATA_W-1:0]           md_pc,
  output logic                        grf_we,
  output logic [REG_ADDR_W-1:0]       grf_a3,
  output logic [DATA_W-1:0]           grf_wd,
  output logic [DATA_W-1:0]           grf_pc,
  output logic [REG_COUNT-1:0]        pend_mask,
  output logic [$clog2(FIFO_DEPTH):0] md_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  pl_elig;
  logic                  md_push;
  logic                  fifo_pop;
  logic                  issue_md;
  logic                  head_live;
  logic [REG_ADDR_W-1:0] head_a3;
  logic [DATA_W-1:0]     head_wd;
  logic [DATA_W-1:0]     head_pc;
  logic                  fifo_empty;

  // Ready comes from registered occupancy only, so a same-cycle pop never opens a full queue.
  assign md_ready = (md_count < CNT_W'(FIFO_DEPTH));
  assign pl_elig  = pl_we && (pl_a3 != '0);
  // r0 results complete the handshake but are dropped.
  assign md_push  = md_valid && md_ready && (md_a3 != '0);
  // Pipeline has priority; a dead head still pops, just without a write.
  assign fifo_pop = !pl_elig && !fifo_empty;
  assign issue_md = fifo_pop && head_live;

  wb_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (md_push),
    .push_a3   (md_a3),
    .push_wd   (md_wd),
    .push_pc   (md_pc),
    .pop       (fifo_pop),
    .inv_en    (pl_elig),
    .inv_a3    (pl_a3),
    .head_live (head_live),
    .head_a3   (head_a3),
    .head_wd   (head_wd),
    .head_pc   (head_pc),
    .empty     (fifo_empty),
    .count     (md_count),
    .pend_mask (pend_mask)
  );

  // Registered write port; address/data/pc hold when nothing issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grf_we <= 1'b0;
      grf_a3 <= '0;
      grf_wd <= '0;
      grf_pc <= '0;
    end else begin
      grf_we <= pl_elig || issue_md;
      if (pl_elig) begin
        grf_a3 <= pl_a3;
        grf_wd <= pl_wd;
        grf_pc <= pl_pc;
      end else if (issue_md) begin
        grf_a3 <= head_a3;
        grf_wd <= head_wd;
        grf_pc <= head_pc;
      end
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Self-checking bench for grf_write_arbiter: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence.
module tb_grf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pl_we;
  logic [4:0]  pl_a3;
  logic [31:0] pl_wd;
  logic [31:0] pl_pc;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;
  logic [31:0] pend_mask;
  logic [2:0]  md_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grf_write_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pl_we     (pl_we),
    .pl_a3     (pl_a3),
    .pl_wd     (pl_wd),
    .pl_pc     (pl_pc),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_a3     (md_a3),
    .md_wd     (md_wd),
    .md_pc     (md_pc),
    .grf_we    (grf_we),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .grf_pc    (grf_pc),
    .pend_mask (pend_mask),
    .md_count  (md_count)
  );

  // One cycle of stimulus; rdy/cnt/mask are expected before the edge,
  // we/a3/wd/pc after it (a3/wd/pc ignored on no-issue rows: they must hold).
  typedef struct {
    bit          pl_we;
    logic [31:0] pl_a3;
    logic [31:0] pl_wd;
    logic [31:0] pl_pc;
    bit          md_valid;
    logic [31:0] md_a3;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    bit          rdy;
    logic [31:0] cnt;
    logic [31:0] mask;
    bit          we;
    logic [31:0] a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    bit          we;
    logic [31:0] a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wr_t;

  vec_t tbl[$];
  wr_t  sb[$];

  function automatic vec_t v(bit plw, logic [31:0] pa, logic [31:0] pw, logic [31:0] pp,
                             bit mv, logic [31:0] ma, logic [31:0] mw, logic [31:0] mp,
                             bit rdy, logic [31:0] cnt, logic [31:0] mask,
                             bit we, logic [31:0] a3, logic [31:0] wd, logic [31:0] pc);
    vec_t r;
    r.pl_we = plw; r.pl_a3 = pa; r.pl_wd = pw; r.pl_pc = pp;
    r.md_valid = mv; r.md_a3 = ma; r.md_wd = mw; r.md_pc = mp;
    r.rdy = rdy; r.cnt = cnt; r.mask = mask;
    r.we = we; r.a3 = a3; r.wd = wd; r.pc = pc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit plw, input logic [31:0] pa, input logic [31:0] pw,
                       input logic [31:0] pp, input bit mv, input logic [31:0] ma,
                       input logic [31:0] mw, input logic [31:0] mp);
    pl_we    = plw;
    pl_a3    = 5'(pa);
    pl_wd    = pw;
    pl_pc    = pp;
    md_valid = mv;
    md_a3    = 5'(ma);
    md_wd    = mw;
    md_pc    = mp;
  endtask

  logic [31:0] last_a3;
  logic [31:0] last_wd;
  logic [31:0] last_pc;
  wr_t         e;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    check("rst grf_we", 32'(grf_we), 0);
    check("rst grf_a3", 32'(grf_a3), 0);
    check("rst grf_wd", grf_wd, 0);
    check("rst grf_pc", grf_pc, 0);
    check("rst md_count", 32'(md_count), 0);
    check("rst pend_mask", pend_mask, 0);
    check("rst md_ready", 32'(md_ready), 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // pl_we,a3,wd,pc | md_valid,a3,wd,pc | rdy,cnt,mask | we,a3,wd,pc
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    tbl.push_back(v(1,5,32'h1234_5678,32'h3000,      0,0,0,0,                      1,0,0,        1,5,32'h1234_5678,32'h3000));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    // fill while pipeline writes r2
    tbl.push_back(v(1,2,32'h22,32'h100,              1,8,32'h80,32'h800,           1,0,0,        1,2,32'h22,32'h100));
    tbl.push_back(v(1,2,32'h23,32'h104,              1,9,32'h90,32'h900,           1,1,32'h100,  1,2,32'h23,32'h104));
    tbl.push_back(v(1,2,32'h24,32'h108,              1,10,32'hA0,32'hA00,          1,2,32'h300,  1,2,32'h24,32'h108));
    tbl.push_back(v(1,2,32'h25,32'h10C,              1,11,32'hB0,32'hB00,          1,3,32'h700,  1,2,32'h25,32'h10C));
    tbl.push_back(v(1,2,32'h26,32'h110,              1,12,32'hC0,32'hC00,          0,4,32'hF00,  1,2,32'h26,32'h110));
    // full, pipeline idle: pop without accepting, then accept
    tbl.push_back(v(0,0,0,0,                         1,12,32'hC0,32'hC00,          0,4,32'hF00,  1,8,32'h80,32'h800));
    tbl.push_back(v(0,0,0,0,                         1,12,32'hC0,32'hC00,          1,3,32'hE00,  1,9,32'h90,32'h900));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,3,32'h1C00, 1,10,32'hA0,32'hA00));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,2,32'h1800, 1,11,32'hB0,32'hB00));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,1,32'h1000, 1,12,32'hC0,32'hC00));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    // supersede a queued r9
    tbl.push_back(v(1,3,32'h33,32'h200,              1,9,32'hAAAA_AAAA,32'h900,    1,0,0,        1,3,32'h33,32'h200));
    tbl.push_back(v(1,9,32'hBBBB_BBBB,32'h204,       0,0,0,0,                      1,1,32'h200,  1,9,32'hBBBB_BBBB,32'h204));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,1,0,        0,0,0,0));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    // push and pipeline write to the same register on one edge
    tbl.push_back(v(1,7,32'h7E,32'h300,              1,7,32'h77,32'h700,           1,0,0,        1,7,32'h7E,32'h300));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,1,0,        0,0,0,0));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    // r0 on both sources
    tbl.push_back(v(1,0,32'h1111,32'h504,            1,0,32'hDEAD,32'h500,         1,0,0,        0,0,0,0));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));
    // push into empty queue while pipeline issues
    tbl.push_back(v(1,6,32'h66,32'h600,              1,4,32'h44,32'h400,           1,0,0,        1,6,32'h66,32'h600));
    tbl.push_back(v(0,5,32'h55,0,                    0,0,0,0,                      1,1,32'h10,   1,4,32'h44,32'h400));
    tbl.push_back(v(0,0,0,0,                         0,0,0,0,                      1,0,0,        0,0,0,0));

    last_a3 = 0;
    last_wd = 0;
    last_pc = 0;
    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].pl_we, tbl[k].pl_a3, tbl[k].pl_wd, tbl[k].pl_pc,
            tbl[k].md_valid, tbl[k].md_a3, tbl[k].md_wd, tbl[k].md_pc);
      #1;
      check($sformatf("v%0d md_ready", k), 32'(md_ready), 32'(tbl[k].rdy));
      check($sformatf("v%0d md_count", k), 32'(md_count), tbl[k].cnt);
      check($sformatf("v%0d pend_mask", k), pend_mask, tbl[k].mask);
      if (tbl[k].we) begin
        last_a3 = tbl[k].a3;
        last_wd = tbl[k].wd;
        last_pc = tbl[k].pc;
      end
      sb.push_back('{we: tbl[k].we, a3: last_a3, wd: last_wd, pc: last_pc});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("v%0d grf_we", k), 32'(grf_we), 32'(e.we));
      check($sformatf("v%0d grf_a3", k), 32'(grf_a3), e.a3);
      check($sformatf("v%0d grf_wd", k), grf_wd, e.wd);
      check($sformatf("v%0d grf_pc", k), grf_pc, e.pc);
    end

    // Queue three results while the pipeline writes r1, then reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 1, 32'h100 + 32'(k), 32'h40 + 32'(k), 1, 32'(13 + k), 32'hD0 + 32'(k), 32'hD00);
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("pre-rst md_count", 32'(md_count), 3);
    check("pre-rst pend_mask", pend_mask, 32'h0000_E000);
    check("pre-rst grf_we", 32'(grf_we), 1);
    #1 reset = 1'b1;
    #1;
    check("async grf_we", 32'(grf_we), 0);
    check("async md_count", 32'(md_count), 0);
    check("async pend_mask", pend_mask, 0);
    check("async md_ready", 32'(md_ready), 1);
    check("async grf_a3", 32'(grf_a3), 0);
    // A pipeline write held across a reset edge must not issue until reset drops.
    @(negedge clk);
    drive(1, 5, 32'h5555, 32'h900, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("in-rst grf_we", 32'(grf_we), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post-rst grf_we", 32'(grf_we), 1);
    check("post-rst grf_a3", 32'(grf_a3), 5);
    check("post-rst grf_wd", grf_wd, 32'h5555);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("drain%0d grf_we", k), 32'(grf_we), 0);
      check($sformatf("drain%0d md_count", k), 32'(md_count), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
